// File: rtl/vga_barrido.sv
// vga_barrido: 640x480@60 VGA timing generator and ADV7123-style DAC output stage.
// Build macro VGA_PATRON_EN swaps the memory colour for an 8-bar test pattern.
module vga_barrido #(
  parameter int DIV      = 2,
  parameter int LATENCIA = 1,
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dato,
  output logic [9:0]  pixelX,
  output logic [9:0]  pixelY,
  output logic        vga_clk,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        fin_cuadro
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_INI = H_VIS + H_FP;
  localparam int HS_FIN = HS_INI + H_SYNC;
  localparam int VS_INI = V_VIS + V_FP;
  localparam int VS_FIN = VS_INI + V_SYNC;

  localparam logic [3:0] DIV_MAX  = 4'(DIV - 1);
  localparam logic [3:0] DIV_HALF = 4'(DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);

  logic [3:0]          div_q, div_d;
  logic                tick_s;
  logic                vga_clk_q, vga_clk_d;
  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic                fin_q, fin_d;
  logic                vis_s, hs_s, vs_s;
  logic [LATENCIA-1:0] vis_q, vis_d;
  logic [LATENCIA-1:0] hs_q, hs_d;
  logic [LATENCIA-1:0] vs_q, vs_d;
  logic [LATENCIA:0]   vis_cad_s, hs_cad_s, vs_cad_s;
  logic [23:0]         color_s;
  logic [23:0]         rgb_q, rgb_d;
  logic                unused_dato_s;

`ifdef VGA_PATRON_EN
  logic [2:0]            banda_s;
  logic [3*LATENCIA-1:0] banda_q, banda_d;
  logic [3*LATENCIA+2:0] banda_cad_s;

  // Bars are 80 px wide; columns past the visible area are masked by blank anyway.
  function automatic logic [2:0] banda_de(input logic [9:0] x);
    logic [2:0] idx;
    if (x < 10'd80) begin
      idx = 3'd0;
    end else if (x < 10'd160) begin
      idx = 3'd1;
    end else if (x < 10'd240) begin
      idx = 3'd2;
    end else if (x < 10'd320) begin
      idx = 3'd3;
    end else if (x < 10'd400) begin
      idx = 3'd4;
    end else if (x < 10'd480) begin
      idx = 3'd5;
    end else if (x < 10'd560) begin
      idx = 3'd6;
    end else begin
      idx = 3'd7;
    end
    return idx;
  endfunction

  function automatic logic [23:0] color_barra(input logic [2:0] banda);
    logic [23:0] c;
    case (banda)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction
`endif

  // Pixel divider, scan counters and frame-end detection
  always_comb begin
    tick_s = (div_q == DIV_MAX);
    div_d  = div_q;
    x_d    = x_q;
    y_d    = y_q;
    fin_d  = 1'b0;
    if (tick_s) begin
      div_d = 4'd0;
      fin_d = (x_q == H_LAST) && (y_q == V_LAST);
      if (x_q == H_LAST) begin
        x_d = 10'd0;
        if (y_q == V_LAST) begin
          y_d = 10'd0;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end else begin
      div_d = div_q + 4'd1;
    end
    // vga_clk tracks the divider phase, so it rises mid-pixel
    vga_clk_d = (div_d >= DIV_HALF);
  end

  // Raw timing from the counters and the alignment shift registers
  always_comb begin
    vis_s     = (x_q < 10'(H_VIS)) && (y_q < 10'(V_VIS));
    hs_s      = !((x_q >= 10'(HS_INI)) && (x_q < 10'(HS_FIN)));
    vs_s      = !((y_q >= 10'(VS_INI)) && (y_q < 10'(VS_FIN)));
    vis_cad_s = {vis_q, vis_s};
    hs_cad_s  = {hs_q, hs_s};
    vs_cad_s  = {vs_q, vs_s};
    vis_d     = vis_cad_s[LATENCIA-1:0];
    hs_d      = hs_cad_s[LATENCIA-1:0];
    vs_d      = vs_cad_s[LATENCIA-1:0];
  end

  // Colour source selection; colour is gated by the value entering the last stage
  always_comb begin
`ifdef VGA_PATRON_EN
    banda_s       = banda_de(x_q);
    banda_cad_s   = {banda_q, banda_s};
    banda_d       = banda_cad_s[3*LATENCIA-1:0];
    color_s       = color_barra(banda_cad_s[3*LATENCIA-1 -: 3]);
    unused_dato_s = ^dato;
`else
    color_s       = dato[23:0];
    unused_dato_s = ^dato[31:24];
`endif
    if (vis_cad_s[LATENCIA-1]) begin
      rgb_d = color_s;
    end else begin
      rgb_d = 24'd0;
    end
  end

  // State registers: divider every clk, counters and pipelines on the pixel tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= 4'd0;
      vga_clk_q <= 1'b0;
      fin_q     <= 1'b0;
      x_q       <= 10'd0;
      y_q       <= 10'd0;
      vis_q     <= {LATENCIA{1'b0}};
      hs_q      <= {LATENCIA{1'b1}};
      vs_q      <= {LATENCIA{1'b1}};
      rgb_q     <= 24'd0;
`ifdef VGA_PATRON_EN
      banda_q   <= {(3*LATENCIA){1'b0}};
`endif
    end else begin
      div_q     <= div_d;
      vga_clk_q <= vga_clk_d;
      fin_q     <= fin_d;
      if (tick_s) begin
        x_q     <= x_d;
        y_q     <= y_d;
        vis_q   <= vis_d;
        hs_q    <= hs_d;
        vs_q    <= vs_d;
        rgb_q   <= rgb_d;
`ifdef VGA_PATRON_EN
        banda_q <= banda_d;
`endif
      end
    end
  end

  assign pixelX     = x_q;
  assign pixelY     = y_q;
  assign vga_clk    = vga_clk_q;
  assign hsync      = hs_q[LATENCIA-1];
  assign vsync      = vs_q[LATENCIA-1];
  assign blank_n    = vis_q[LATENCIA-1];
  assign sync_n     = 1'b0;
  assign r          = rgb_q[23:16];
  assign g          = rgb_q[15:8];
  assign b          = rgb_q[7:0];
  assign fin_cuadro = fin_q;

endmodule
